// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Header layout is {len, addr} with len in the MSBs.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HDR,
        PLD,
        PAR
    } tx_state_t;

    function automatic logic [DATA_W-1:0] hdr_pack(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host command/payload and router-side bundle for router_pkt_tx.
// ROUTER_TX_ERR_INJ_EN adds the inj_err command sideband.
interface router_pkt_tx_if;
    import router_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              pl_valid;
    logic              pl_ready;
    logic [DATA_W-1:0] pl_data;
    logic              busy;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              err_len;
`ifdef ROUTER_TX_ERR_INJ_EN
    logic              inj_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, inj_err,
        output pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid,
        input  data_out, done, err_len
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, inj_err,
        input  pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid,
        output data_out, done, err_len
    );
`else
    modport master (
        output cmd_valid, cmd_addr, cmd_len,
        output pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid,
        input  data_out, done, err_len
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
        input  pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid,
        output data_out, done, err_len
    );
`endif

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer: register array, one write port, one registered read port.
// A same-cycle write to the read address is forwarded (write-first).
module router_tx_buf #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) rdata <= wdata;
        else                        rdata <= mem[raddr];
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source: header, payload, parity, back-to-back.
// Define ROUTER_TX_ERR_INJ_EN to add inj_err (flips parity bit 0).
module router_pkt_tx
    import router_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    router_pkt_tx_if.slave bus
);

    tx_state_t         state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] parity;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] par_out;
    logic              pkt_valid_q;
    logic              done_q;
    logic              err_len_q;
    logic              we;
    logic              consume;

    assign consume = !bus.busy;
    assign we      = (state == LOAD) && bus.pl_valid;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.pl_ready  = (state == LOAD);
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.err_len   = err_len_q;

`ifdef ROUTER_TX_ERR_INJ_EN
    logic inj_q;
    assign par_out = parity ^ {{(DATA_W-1){1'b0}}, inj_q};
`else
    assign par_out = parity;
`endif

    // Read address runs one beat ahead so rdata is ready when a beat is consumed
    always_comb begin
        raddr = '0;
        unique case (state)
            HDR:     raddr = consume ? LEN_W'(1) : '0;
            PLD:     raddr = consume ? rd_ptr + 1'b1 : rd_ptr;
            default: raddr = '0;
        endcase
    end

    router_tx_buf #(
        .AW (LEN_W),
        .DW (DATA_W)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (bus.pl_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            parity      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_len != '0) begin
                            addr_q <= bus.cmd_addr;
                            len_q  <= bus.cmd_len;
                            parity <= hdr_pack(bus.cmd_len, bus.cmd_addr);
                            wr_ptr <= '0;
`ifdef ROUTER_TX_ERR_INJ_EN
                            inj_q  <= bus.inj_err;
`endif
                            state  <= LOAD;
                        end else begin
                            err_len_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.pl_valid) begin
                        parity <= parity ^ bus.pl_data;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == len_q - 1'b1) begin
                            data_q      <= hdr_pack(len_q, addr_q);
                            pkt_valid_q <= 1'b1;
                            state       <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (consume) begin
                        data_q <= rdata;
                        rd_ptr <= LEN_W'(1);
                        state  <= PLD;
                    end
                end
                PLD: begin
                    if (consume) begin
                        if (rd_ptr == len_q) begin
                            data_q      <= par_out;
                            pkt_valid_q <= 1'b0;
                            state       <= PAR;
                        end else begin
                            data_q <= rdata;
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (consume) begin
                        data_q <= '0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Store-and-forward packet transmitter. It is the source end of the router input protocol.
- Accepts a command (addr, len) and len payload bytes from a host, buffers the whole payload, then drives the router input back-to-back: header, payload, then parity.
- Sits between host/test logic and the router top `data_in`/`pkt_valid`/`busy` interface.

Parameters:
- DATA_W, 8, byte width. Must equal LEN_W+ADDR_W.
- LEN_W, 6, payload-length field width. Buffer depth is 2**LEN_W.
- ADDR_W, 2, destination-port field width.

Ports:
- clk  in  1  clock; all flops rise on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  destination port.
- cmd_len  in  LEN_W  payload length; 0 is illegal.
- pl_valid  in  1  payload byte valid.
- pl_ready  out  1  high only in LOAD.
- pl_data  in  DATA_W  payload byte.
- busy  in  1  router busy; the presented byte is held while high.
- pkt_valid  out  1  to router; high for header and payload, low for parity.
- data_out  out  DATA_W  to router `data_in`.
- done  out  1  one-cycle pulse after the parity byte is consumed.
- err_len  out  1  one-cycle pulse when a len==0 command is rejected.

Behaviour:
- Reset (async, rst=0): state=IDLE; pkt_valid=0, data_out=0, done=0, err_len=0; pointers and parity cleared. Buffer contents are don't-care.
- All outputs are registered. cmd_ready and pl_ready are decoded from state.
- Header format: header = {len, addr}, len in the MSBs. Parity = header XOR all payload bytes.
- A byte is consumed at a posedge where busy=0. While busy=1, data_out and pkt_valid hold.
- IDLE: on cmd_valid&&cmd_ready:
  - len!=0: latch addr/len, parity<=header, wr_ptr<=0, go LOAD.
  - len==0: err_len=1 next cycle, stay IDLE.
- LOAD: on each pl_valid, mem[wr_ptr]<=pl_data, parity^=pl_data, wr_ptr++.
  - On the write with wr_ptr==len-1: next cycle data_out=header, pkt_valid=1, go HDR.
  - Gaps in pl_valid are allowed and simply stall LOAD.
- HDR: on consume, data_out<=mem[0], rd_ptr<=1, go PLD.
- PLD: on consume:
  - rd_ptr==len: data_out<=parity, pkt_valid<=0, go PAR.
  - Otherwise: data_out<=mem[rd_ptr], rd_ptr++.
- PAR: on consume, data_out<=0, done=1 for one cycle, go IDLE.
- Latency:
  - Header appears 1 cycle after the last payload write.
  - With busy=0, the packet occupies exactly len+2 consecutive cycles with no bubbles.
  - done asserts the cycle after parity is consumed.
- pkt_valid never deasserts mid-payload. Busy only extends a beat; it never drops or duplicates one.
- busy is ignored in IDLE and LOAD.
- cmd_valid outside IDLE is ignored (cmd_ready=0). pl_valid outside LOAD is ignored.
- len=2**LEN_W-1 fills the buffer to depth-1; wr_ptr and rd_ptr never wrap within a packet.
- Reset mid-packet: outputs return to their reset values immediately; the partial packet is discarded.

Optional Feature:
- ROUTER_TX_ERR_INJ_EN defined:
  - Adds input port inj_err (1 bit), sampled at the command handshake.
  - If set, the transmitted parity byte is parity^8'h01, so the router must flag err.
- Undefined: the port is absent and parity is always correct.

Decomposition:
- Shared package router_pkg:
  - DATA_W/LEN_W/ADDR_W constants.
  - tx_state_t enum (IDLE, LOAD, HDR, PLD, PAR).
  - Header pack function {len, addr}.
- Sub-module router_tx_buf: simple-dual-port 2**LEN_W x DATA_W register array with write port (we, waddr, wdata) and synchronous read. Alternatively, pre-fetch so the read aligns with the PLD advance.

Test Plan:
- Good packet: cmd addr=2, len=5; payload 0x11,0x22,0x33,0x44,0x55; busy=0 -> data_out 0x16,0x11..0x55 with pkt_valid=1 for 6 cycles, then 0x16^0x11^0x22^0x33^0x44^0x55=0x07 with pkt_valid=0; done pulses 1 cycle later.
- Busy stall: same packet, busy=1 for 3 cycles while 0x33 is presented -> 0x33 held 4 cycles, no duplicate or skip; total length 7+3 cycles.
- Zero length: cmd len=0 -> err_len pulse, cmd_ready stays 1, pkt_valid stays 0.
- Max length with payload gaps: len=63 with random pl_valid gaps -> 65 bytes out back-to-back, parity correct, rd/wr pointers never wrap.
- Reset mid-PLD: rst=0 during byte 3 -> pkt_valid=0 and data_out=0 asynchronously; a new packet after reset is transmitted correctly.
- ROUTER_TX_ERR_INJ_EN build, inj_err=1 -> parity byte is the correct value with bit0 inverted; router err asserts.
